// File: rtl/vga_pkg.sv
// Shared raster constants for the character-cell VGA path (800x600@60, 40 MHz pixel clock).
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 23;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned H_CNT_W  = 11;
  localparam int unsigned V_CNT_W  = 10;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned COLOR_W  = 3 * CH_W;

  // Cell colour as delivered by the controller: {R[8:6], G[5:3], B[2:0]}
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_pipe_dly.sv
// Fixed-depth shift register that resets to a caller-supplied idle pattern.
module vga_pipe_dly #(
  parameter int unsigned      WIDTH   = 3,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) sr_q[i] <= RST_VAL;
    end else begin
      sr_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: counters, frame-boundary run control, sync/blank alignment and RGB pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned SYNC_POL = 1,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [COLOR_W-1:0] color_in,
  output logic               vga_data_en,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [CH_W-1:0]    vga_r,
  output logic [CH_W-1:0]    vga_g,
  output logic [CH_W-1:0]    vga_b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_SYNC_BEG = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] H_SYNC_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_SYNC_BEG = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] V_SYNC_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
  localparam logic               POL        = 1'(SYNC_POL);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (PIPE_DLY > 7 || SYNC_POL > 1) begin : g_misc_chk
    $error("vga_timing_gen: PIPE_DLY must be 0..7 and SYNC_POL 0 or 1");
  end

  logic [0:0] state_q, state_d;
  logic       running, h_last, v_last, frame_last;
  logic       de_raw, hs_raw, vs_raw;
  logic       de_dly, hs_dly, vs_dly;
  rgb_t       rgb_q;

  assign running    = (state_q == ST_RUN);
  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_last = h_last && v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // enable is only looked at from idle or on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (frame_last && !enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + V_CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + H_CNT_W'(1);
    end
  end

  assign de_raw = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs_raw = (running && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) ? POL : ~POL;
  assign vs_raw = (running && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) ? POL : ~POL;
  assign vga_data_en = de_raw;

  // Align blank/sync with the controller's colour latency
  if (PIPE_DLY > 0) begin : g_dly
    vga_pipe_dly #(
      .WIDTH  (3),
      .DEPTH  (PIPE_DLY),
      .RST_VAL({1'b0, ~POL, ~POL})
    ) u_pipe_dly (
      .clk  (clk),
      .rst_n(rst_n),
      .din  ({de_raw, hs_raw, vs_raw}),
      .dout ({de_dly, hs_dly, vs_dly})
    );
  end else begin : g_nodly
    assign {de_dly, hs_dly, vs_dly} = {de_raw, hs_raw, vs_raw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      rgb_q       <= '0;
    end else begin
      frame_start <= running && (h_cnt == '0) && (v_cnt == '0);
      hsync       <= hs_dly;
      vsync       <= vs_dly;
      rgb_q       <= de_dly ? rgb_t'(color_in) : '0;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 32x16 raster, PIPE_DLY = 0, 1 and 3 side by side.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
  localparam int VA = 10, VFP = 1, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int NEVER = 1 << 30;

  logic        clk, rst_n, enable;
  logic [8:0]  color   [3];
  logic        de      [3];
  logic [10:0] h_cnt   [3];
  logic [9:0]  v_cnt   [3];
  logic        fs      [3];
  logic        hs      [3];
  logic        vs      [3];
  logic [2:0]  r       [3];
  logic [2:0]  g       [3];
  logic [2:0]  b       [3];
  logic        de_sr1;
  logic [2:0]  de_sr3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                   .SYNC_POL(1), .PIPE_DLY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .color_in(color[0]),
    .vga_data_en(de[0]), .h_cnt(h_cnt[0]), .v_cnt(v_cnt[0]), .frame_start(fs[0]),
    .hsync(hs[0]), .vsync(vs[0]), .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                   .SYNC_POL(1), .PIPE_DLY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .color_in(color[1]),
    .vga_data_en(de[1]), .h_cnt(h_cnt[1]), .v_cnt(v_cnt[1]), .frame_start(fs[1]),
    .hsync(hs[1]), .vsync(vs[1]), .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                   .SYNC_POL(1), .PIPE_DLY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .color_in(color[2]),
    .vga_data_en(de[2]), .h_cnt(h_cnt[2]), .v_cnt(v_cnt[2]), .frame_start(fs[2]),
    .hsync(hs[2]), .vsync(vs[2]), .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]));

  // Cell-controller stand-in: 1C7 only on the delayed active window, junk elsewhere
  always @(posedge clk) begin
    de_sr1 <= de[1];
    de_sr3 <= {de_sr3[1:0], de[2]};
  end
  assign color[0] = de[0]     ? 9'h1C7 : 9'h03A;
  assign color[1] = de_sr1    ? 9'h1C7 : 9'h03A;
  assign color[2] = de_sr3[2] ? 9'h1C7 : 9'h03A;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference raster: m = cycles since the first running cycle, running for m in [0, stop_n)
  function automatic bit run_at(int m, int stop_n);
    return (m >= 0) && (m < stop_n);
  endfunction
  function automatic int h_at(int m, int stop_n);
    return run_at(m, stop_n) ? (m % HT) : 0;
  endfunction
  function automatic int v_at(int m, int stop_n);
    return run_at(m, stop_n) ? ((m / HT) % VT) : 0;
  endfunction
  function automatic bit de_at(int m, int stop_n);
    return run_at(m, stop_n) && (h_at(m, stop_n) < HA) && (v_at(m, stop_n) < VA);
  endfunction
  function automatic bit hs_at(int m, int stop_n);
    return run_at(m, stop_n) && (h_at(m, stop_n) >= HA + HFP) && (h_at(m, stop_n) < HA + HFP + HS);
  endfunction
  function automatic bit vs_at(int m, int stop_n);
    return run_at(m, stop_n) && (v_at(m, stop_n) >= VA + VFP) && (v_at(m, stop_n) < VA + VFP + VS);
  endfunction

  task automatic check_cycle(input int n, input int stop_n);
    int d;
    bit fs_exp;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 0 : (k == 1) ? 1 : 3;
      fs_exp = run_at(n - 1, stop_n) && (h_at(n - 1, stop_n) == 0) && (v_at(n - 1, stop_n) == 0);
      check_val($sformatf("dly%0d h_cnt n=%0d", d, n), int'(h_cnt[k]), h_at(n, stop_n));
      check_val($sformatf("dly%0d v_cnt n=%0d", d, n), int'(v_cnt[k]), v_at(n, stop_n));
      check_val($sformatf("dly%0d data_en n=%0d", d, n), int'(de[k]), int'(de_at(n, stop_n)));
      check_val($sformatf("dly%0d frame_start n=%0d", d, n), int'(fs[k]), int'(fs_exp));
      check_val($sformatf("dly%0d hsync n=%0d", d, n), int'(hs[k]), int'(hs_at(n - d - 1, stop_n)));
      check_val($sformatf("dly%0d vsync n=%0d", d, n), int'(vs[k]), int'(vs_at(n - d - 1, stop_n)));
      check_val($sformatf("dly%0d rgb n=%0d", d, n), int'({r[k], g[k], b[k]}),
                de_at(n - d - 1, stop_n) ? 'h1C7 : 0);
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_cycle(-1, 0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_cycle(-1, 0);

    // Three frames; enable drops mid-way through the third, which must still complete
    enable = 1'b1;
    for (int n = 0; n <= 3 * FRAME + 12; n++) begin
      @(negedge clk);
      check_cycle(n, 3 * FRAME);
      if (n == 2 * FRAME + 5 * HT) enable = 1'b0;
    end

    // Restart from idle, then hit reset mid-line in line 3
    enable = 1'b1;
    for (int n = 0; n <= 3 * HT + 12; n++) begin
      @(negedge clk);
      check_cycle(n, NEVER);
    end
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check_cycle(-1, 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_cycle(-1, 0);
    enable = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      check_cycle(n, NEVER);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
